// File: rtl/multimode_counter.sv
// Up/down counter over DIGITS nibbles, binary or cascaded-BCD, with load/clear,
// optional saturation, a one-cycle carry pulse and a sticky overflow flag.
module multimode_counter #(
    parameter int unsigned DIGITS   = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk_count,
    input  logic                  reset_count,
    input  logic                  enable_count,
    input  logic                  mode_bcd,
    input  logic                  dir_down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  overflow
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam logic [W-1:0] OneW = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;
    logic         r_carry;
    logic         r_overflow;

    logic [W-1:0] w_bcd_next;
    logic [W-1:0] w_bin_next;
    logic [W-1:0] w_wrap_next;
    logic [W-1:0] w_step_next;
    logic [3:0]   w_dig;
    logic         w_up_chain;
    logic         w_dn_chain;
    logic         w_bcd_term;
    logic         w_bin_term;
    logic         w_term;

    // Decade ripple: a digit steps only when every lower clamped digit is at its limit.
    always_comb begin
        w_up_chain = 1'b1;
        w_dn_chain = 1'b1;
        w_bcd_next = '0;
        w_dig      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = (r_count[4*i +: 4] > 4'd9) ? 4'd9 : r_count[4*i +: 4];
            if (!dir_down && w_up_chain) begin
                w_bcd_next[4*i +: 4] = (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
            end else if (dir_down && w_dn_chain) begin
                w_bcd_next[4*i +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
            end else begin
                w_bcd_next[4*i +: 4] = w_dig;
            end
            w_up_chain = w_up_chain & (w_dig == 4'd9);
            w_dn_chain = w_dn_chain & (w_dig == 4'd0);
        end
        w_bcd_term = dir_down ? w_dn_chain : w_up_chain;
    end

    always_comb begin
        w_bin_next = dir_down ? (r_count - OneW) : (r_count + OneW);
        w_bin_term = dir_down ? (r_count == '0) : (&r_count);
    end

    // The natural ripple result already equals the wrap target at the terminal value.
    always_comb begin
        w_term      = mode_bcd ? w_bcd_term : w_bin_term;
        w_wrap_next = mode_bcd ? w_bcd_next : w_bin_next;
        w_step_next = (w_term && SATURATE) ? r_count : w_wrap_next;
    end

    always_ff @(posedge clk_count or posedge reset_count) begin
        if (reset_count) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (load) begin
            r_count <= load_value;
            r_carry <= 1'b0;
        end else if (enable_count) begin
            r_count    <= w_step_next;
            r_carry    <= w_term;
            r_overflow <= r_overflow | w_term;
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign count    = r_count;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_multimode_counter.sv
// Randomised + directed bench for multimode_counter: wrap and saturating instances
// share stimulus; a decimal/binary arithmetic model feeds a scoreboard queue.
module tb_multimode_counter;

    localparam int D = 8;
    localparam int W = 4 * D;

    logic         clk_count = 1'b0;
    logic         clk_run   = 1'b1;
    logic         reset_count;
    logic         enable_count;
    logic         mode_bcd;
    logic         dir_down;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;

    logic [W-1:0] count_w, count_s;
    logic         carry_w, carry_s, ovf_w, ovf_s;

    multimode_counter #(.DIGITS(D), .SATURATE(1'b0)) u_wrap (
        .clk_count    (clk_count),
        .reset_count  (reset_count),
        .enable_count (enable_count),
        .mode_bcd     (mode_bcd),
        .dir_down     (dir_down),
        .clear        (clear),
        .load         (load),
        .load_value   (load_value),
        .count        (count_w),
        .carry        (carry_w),
        .overflow     (ovf_w)
    );

    multimode_counter #(.DIGITS(D), .SATURATE(1'b1)) u_sat (
        .clk_count    (clk_count),
        .reset_count  (reset_count),
        .enable_count (enable_count),
        .mode_bcd     (mode_bcd),
        .dir_down     (dir_down),
        .clear        (clear),
        .load         (load),
        .load_value   (load_value),
        .count        (count_s),
        .carry        (carry_s),
        .overflow     (ovf_s)
    );

    always #5 if (clk_run) clk_count = ~clk_count;

    typedef struct packed {
        logic [W-1:0] cw;
        logic         kw;
        logic         ow;
        logic [W-1:0] cs;
        logic         ks;
        logic         os;
    } exp_t;

    exp_t sb[$];
    event async_chk;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] m_cw, m_cs;
    logic         m_kw, m_ow, m_ks, m_os;

    function automatic longint unsigned bcd_lim();
        longint unsigned v = 1;
        for (int i = 0; i < D; i++) v = v * 10;
        return v;
    endfunction

    // Clamped digits read as a decimal number.
    function automatic longint unsigned bcd_val(input logic [W-1:0] c);
        longint unsigned v = 0;
        logic [3:0]      nib;
        for (int i = D - 1; i >= 0; i--) begin
            nib = c[4*i +: 4];
            if (nib > 4'd9) nib = 4'd9;
            v = v * 10 + longint'(nib);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint unsigned v);
        logic [W-1:0]    r = '0;
        longint unsigned t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Returns {carry_event, next_count} for one enabled step.
    function automatic logic [W:0] model_step(input logic [W-1:0] c, input bit bcd,
                                              input bit down, input bit sat);
        longint unsigned lim, v, nv;
        bit              term;
        logic [W-1:0]    nxt;
        lim  = bcd ? bcd_lim() : 64'h1_0000_0000;
        v    = bcd ? bcd_val(c) : longint'(c);
        term = down ? (v == 0) : (v == lim - 1);
        if (term)      nv = down ? lim - 1 : 0;
        else if (down) nv = v - 1;
        else           nv = v + 1;
        nxt = bcd ? to_bcd(nv) : nv[W-1:0];
        if (term && sat) nxt = c;
        return {term, nxt};
    endfunction

    task automatic model_edge();
        logic [W:0] r;
        if (clear) begin
            m_cw = '0; m_kw = 0; m_ow = 0;
            m_cs = '0; m_ks = 0; m_os = 0;
        end else if (load) begin
            m_cw = load_value; m_kw = 0;
            m_cs = load_value; m_ks = 0;
        end else if (enable_count) begin
            r = model_step(m_cw, mode_bcd, dir_down, 1'b0);
            m_cw = r[W-1:0]; m_kw = r[W]; m_ow = m_ow | r[W];
            r = model_step(m_cs, mode_bcd, dir_down, 1'b1);
            m_cs = r[W-1:0]; m_ks = r[W]; m_os = m_os | r[W];
        end else begin
            m_kw = 0; m_ks = 0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.cw = m_cw; e.kw = m_kw; e.ow = m_ow;
        e.cs = m_cs; e.ks = m_ks; e.os = m_os;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_cw = '0; m_kw = 0; m_ow = 0;
        m_cs = '0; m_ks = 0; m_os = 0;
    endtask

    task automatic cyc(input bit en, input bit dn, input bit bcd, input bit clr,
                       input bit ld, input logic [W-1:0] val);
        enable_count = en;
        dir_down     = dn;
        mode_bcd     = bcd;
        clear        = clr;
        load         = ld;
        load_value   = val;
        @(posedge clk_count);
        #1;
        model_edge();
        push_exp();
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the oldest expectation whenever outputs are settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_count or async_chk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wrap.count",    count_w,      e.cw);
                chk("wrap.carry",    W'(carry_w),  W'(e.kw));
                chk("wrap.overflow", W'(ovf_w),    W'(e.ow));
                chk("sat.count",     count_s,      e.cs);
                chk("sat.carry",     W'(carry_s),  W'(e.ks));
                chk("sat.overflow",  W'(ovf_s),    W'(e.os));
            end
        end
    end

    logic [W-1:0] pick [7];

    initial begin
        bit           bcd_r, dn_r, en_r, clr_r, ld_r;
        int           r;
        logic [W-1:0] v;

        reset_count  = 1'b1;
        enable_count = 0; mode_bcd = 0; dir_down = 0; clear = 0; load = 0;
        load_value   = '0;
        model_reset();
        #12;
        push_exp();
        -> async_chk;
        @(negedge clk_count);
        reset_count = 1'b0;

        // BCD up wrap
        cyc(0, 0, 1, 0, 1, 32'h9999_9998);
        cyc(1, 0, 1, 0, 0, '0);
        cyc(1, 0, 1, 0, 0, '0);
        cyc(0, 0, 1, 0, 0, '0);
        // BCD digit roll up then down
        cyc(0, 0, 1, 0, 1, 32'h0000_0199);
        cyc(1, 0, 1, 0, 0, '0);
        cyc(1, 1, 1, 0, 0, '0);
        cyc(1, 1, 1, 0, 0, '0);
        // Binary down from zero: saturate holds, wrap goes to all-ones
        cyc(1, 0, 0, 1, 0, '0);
        cyc(1, 1, 0, 0, 0, '0);
        cyc(1, 1, 0, 0, 0, '0);
        cyc(1, 1, 0, 0, 0, '0);
        cyc(0, 1, 0, 1, 0, '0);
        // Invalid-BCD clamp
        cyc(0, 0, 1, 0, 1, 32'h0000_003C);
        cyc(1, 0, 1, 0, 0, '0);
        cyc(0, 1, 1, 0, 1, 32'h0000_000F);
        cyc(1, 1, 1, 0, 0, '0);
        // Priority: clear > load > enable
        cyc(1, 0, 0, 1, 1, 32'h0000_1234);
        cyc(1, 0, 0, 0, 1, 32'h0000_1234);
        // Binary up wrap from all-ones
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, '0);

        // Async reset with clock parked low
        cyc(0, 0, 0, 0, 1, 32'h0000_0055);
        @(negedge clk_count);
        clk_run = 1'b0;
        #2;
        reset_count = 1'b1;
        #3;
        reset_count = 1'b0;
        #1;
        model_reset();
        push_exp();
        -> async_chk;
        #1;
        clk_run = 1'b1;
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, '0);

        pick[0] = 32'h9999_9998; pick[1] = 32'hFFFF_FFFE; pick[2] = 32'h0000_0000;
        pick[3] = 32'h0000_0001; pick[4] = 32'h9999_9990; pick[5] = 32'h0000_0009;
        pick[6] = 32'hFFFF_FFF0;
        bcd_r = 1; dn_r = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) bcd_r = ~bcd_r;
            if ($urandom_range(0, 9) == 0)  dn_r  = ~dn_r;
            r     = int'($urandom_range(0, 99));
            clr_r = (r < 2);
            ld_r  = (r >= 2 && r < 8);
            en_r  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) v = pick[$urandom_range(0, 6)];
            else                            v = $urandom;
            cyc(en_r, dn_r, bcd_r, clr_r, ld_r, v);
        end
        cyc(0, 0, 0, 0, 0, '0);

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk_count);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
